alu_core: RTL and testbench

//  Registered 2-operand integer ALU: ADD, SUB, AND, OR on unsigned DATA_W-bit operands.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_addsub.sv | 34 +++
 rtl/alu_core.sv | 70 +++++++
 tb/tb_alu_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered integer ALU: opcode encoding
// and the default datapath width.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OPC_ADD = 2'd0,
        OPC_SUB = 2'd1,
        OPC_AND = 2'd2,
        OPC_OR  = 2'd3
    } opc_e;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Combinational DATA_W+1 bit adder/subtractor. The extra top bit is the
// unsigned carry on add, and the borrow (A < B) on subtract.
module alu_addsub #(
    parameter int DATA_W = alu_pkg::DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cb_o
);

    logic [DATA_W:0] extA;
    logic [DATA_W:0] extB;
    logic [DATA_W:0] extRes;

    assign extA = {1'b0, a_i};
    assign extB = {1'b0, b_i};

    // Zero-extending both operands makes the top result bit the carry on
    // add and the borrow on subtract without any extra compare logic.
    always_comb begin
        extRes = '0;
        if (sub_i) begin
            extRes = extA - extB;
        end else begin
            extRes = extA + extB;
        end
    end

    assign sum_o = extRes[DATA_W-1:0];
    assign cb_o  = extRes[DATA_W];

endmodule : alu_addsub

// File: rtl/alu_core.sv
// Registered two-operand ALU (ADD/SUB/AND/OR) with one cycle latency.
// Outputs are forced to zero while reset is asserted, independent of the
// clock, so downstream logic never sees a stale result during reset.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk_i,
    input  logic              Reset_n_i,
    input  logic [1:0]        Opc_i,
    input  logic [DATA_W-1:0] DinA_i,
    input  logic [DATA_W-1:0] DinB_i,
    output logic [DATA_W-1:0] Dout_o,
    output logic              OverFlow_o
);

    opc_e              opc;
    logic [DATA_W-1:0] addSubRes;
    logic              addSubCb;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;
    logic              flag_d;
    logic              flag_q;

    assign opc = opc_e'(Opc_i);

    alu_addsub #(
        .DATA_W (DATA_W)
    ) u_addsub (
        .a_i   (DinA_i),
        .b_i   (DinB_i),
        .sub_i (opc == OPC_SUB),
        .sum_o (addSubRes),
        .cb_o  (addSubCb)
    );

    // Select the next result and flag by opcode; logic ops never set the flag.
    always_comb begin
        result_d = '0;
        flag_d   = 1'b0;
        case (opc)
            OPC_ADD, OPC_SUB: begin
                result_d = addSubRes;
                flag_d   = addSubCb;
            end
            OPC_AND: result_d = DinA_i & DinB_i;
            OPC_OR:  result_d = DinA_i | DinB_i;
            default: begin
                result_d = '0;
                flag_d   = 1'b0;
            end
        endcase
    end

    // Capture a new result every cycle; a reset edge discards any pending value.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign Dout_o     = Reset_n_i ? result_q : '0;
    assign OverFlow_o = Reset_n_i ? flag_q   : 1'b0;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, reset corner
// sequences, and randomized traffic against a behavioural model.
module tb_alu_core;

    localparam int W = 32;

    logic         clock;
    logic         resetN;
    logic [1:0]   opc;
    logic [W-1:0] dinA;
    logic [W-1:0] dinB;
    logic [W-1:0] dout;
    logic         overFlow;

    int nCompared;
    int nMismatched;

    typedef struct {
        string        name;
        logic [1:0]   opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expD;
        logic         expF;
    } vec_t;

    vec_t vecs[8];

    alu_core #(
        .DATA_W (W)
    ) dut (
        .Clk_i      (clock),
        .Reset_n_i  (resetN),
        .Opc_i      (opc),
        .DinA_i     (dinA),
        .DinB_i     (dinB),
        .Dout_o     (dout),
        .OverFlow_o (overFlow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: plain unsigned arithmetic on wide integers.
    function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] d, output logic f);
        longint unsigned la;
        longint unsigned lb;
        longint unsigned s;
        la = longint'(a);
        lb = longint'(b);
        d  = '0;
        f  = 1'b0;
        case (op)
            2'd0: begin
                s = la + lb;
                d = W'(s % 64'h1_0000_0000);
                f = (s >= 64'h1_0000_0000);
            end
            2'd1: begin
                d = W'((la + 64'h1_0000_0000 - lb) % 64'h1_0000_0000);
                f = (la < lb);
            end
            2'd2: d = a & b;
            default: d = a | b;
        endcase
    endfunction

    // Drive one set of inputs just after a falling edge.
    task automatic applyStimulus(input logic rstN, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        resetN = rstN;
        opc    = op;
        dinA   = a;
        dinB   = b;
    endtask

    // Compare outputs with the expected pair, counting each field separately.
    task automatic checkOutput(input string name, input logic [W-1:0] expD, input logic expF);
        nCompared++;
        if (dout !== expD) begin
            nMismatched++;
            $display("[TB] FAIL %s Dout: got %h expected %h", name, dout, expD);
        end
        nCompared++;
        if (overFlow !== expF) begin
            nMismatched++;
            $display("[TB] FAIL %s OverFlow: got %b expected %b", name, overFlow, expF);
        end
    endtask

    // Wait for the capturing edge and sample just after it.
    task automatic afterEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [W-1:0] expD;
        logic         expF;
        logic [1:0]   rOp;
        logic [W-1:0] rA;
        logic [W-1:0] rB;
        logic         rRst;

        nCompared   = 0;
        nMismatched = 0;
        resetN      = 1'b0;
        opc         = 2'd0;
        dinA        = 32'hFFFF_FFFF;
        dinB        = 32'h1;

        vecs[0] = '{"add_wrap",  2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[1] = '{"add_small", 2'd0, 32'd5,         32'd7,         32'd12,        1'b0};
        vecs[2] = '{"sub_borrow",2'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1};
        vecs[3] = '{"sub_equal", 2'd1, 32'd9,         32'd9,         32'h0000_0000, 1'b0};
        vecs[4] = '{"and_mask",  2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[5] = '{"or_mask",   2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
        vecs[6] = '{"sub_zero_one", 2'd1, 32'h0,      32'h1,         32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{"add_zero",  2'd0, 32'h0,         32'h0,         32'h0000_0000, 1'b0};

        // Before any clock edge, reset must already force outputs low.
        #1;
        checkOutput("reset_pre_edge", '0, 1'b0);

        // Reset held for three cycles with random operations on the inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
            #1;
            checkOutput("reset_low_phase", '0, 1'b0);
            afterEdge();
            checkOutput("reset_after_edge", '0, 1'b0);
        end

        // Directed table, issued back-to-back; each result checked one cycle later.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].opc, vecs[i].a, vecs[i].b);
            afterEdge();
            checkOutput(vecs[i].name, vecs[i].expD, vecs[i].expF);
        end

        // Mid-stream reset right after an overflowing add.
        applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h10);
        afterEdge();
        checkOutput("pre_reset_add", 32'h0000_000F, 1'b1);
        applyStimulus(1'b0, 2'd3, 32'h1234_5678, 32'h0);
        #1;
        checkOutput("midreset_immediate", '0, 1'b0);
        afterEdge();
        checkOutput("midreset_after_edge", '0, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'd100, 32'd58);
        #1;
        checkOutput("release_before_edge", '0, 1'b0);
        afterEdge();
        checkOutput("first_after_release", 32'd42, 1'b0);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            rRst = ($urandom_range(0, 19) != 0);
            rOp  = 2'($urandom_range(0, 3));
            rA   = $urandom;
            rB   = (i % 7 == 0) ? rA : $urandom;
            applyStimulus(rRst, rOp, rA, rB);
            if (rRst) begin
                refModel(rOp, rA, rB, expD, expF);
            end else begin
                expD = '0;
                expF = 1'b0;
            end
            afterEdge();
            checkOutput("random", expD, expF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_alu_core
